// File: rtl/lcd_init_seq_if.sv
// LCD write-FIFO port bundle: push strobe, word, word type and FIFO-full.
// The sequencer drives through 'master'; the FIFO side uses 'slave'.
interface lcd_init_seq_if;
  logic        wfull;
  logic        winc;
  logic [15:0] wdata;
  logic        ID;

  modport master (input wfull, output winc, output wdata, output ID);
  modport slave  (output wfull, input winc, input wdata, input ID);
endinterface

// File: rtl/lcd_init_seq.sv
// LCD power-up initialisation sequencer.
// On a rising edge of init_mode it optionally pulses the LCD hardware reset,
// then walks a fixed command ROM, pushing CMD/DATA words into the LCD write
// FIFO, honouring DLY entries in milliseconds, and pulses init_end at END.
// Optional feature macro: LCD_INIT_HWRST_EN compiles in the hard-reset phase
// (RST_LO then RST_WAIT). Without it, start goes straight to FETCH and
// lcd_rst_n is tied high.
module lcd_init_seq #(
  parameter int CYC_PER_MS  = 50000,
  parameter int RST_LOW_MS  = 10,
  parameter int RST_WAIT_MS = 120
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           init_mode,
  lcd_init_seq_if.master wr,
  output logic           init_end,
  output logic           lcd_rst_n,
  output logic           busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
`ifdef LCD_INIT_HWRST_EN
    RST_LO   = 3'd1,
    RST_WAIT = 3'd2,
`endif
    FETCH    = 3'd3,
    WRITE    = 3'd4,
    DELAY    = 3'd5,
    DONE     = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    ENT_CMD  = 2'd0,
    ENT_DATA = 2'd1,
    ENT_DLY  = 2'd2,
    ENT_END  = 2'd3
  } entry_e;

  // The prescaler is 20 bits and the ms counter 16 bits; refuse settings
  // that cannot be represented rather than silently truncating them.
  if (CYC_PER_MS < 1 || CYC_PER_MS > (1 << 20) ||
      RST_LOW_MS < 0 || RST_LOW_MS > 65535 ||
      RST_WAIT_MS < 0 || RST_WAIT_MS > 65535) begin : g_bad_params
    $error("lcd_init_seq: timing parameter out of range");
  end

  localparam logic [19:0] PRESC_LAST = 20'(CYC_PER_MS - 1);
`ifdef LCD_INIT_HWRST_EN
  localparam logic [15:0] RST_LOW_MS16  = 16'(RST_LOW_MS);
  localparam logic [15:0] RST_WAIT_MS16 = 16'(RST_WAIT_MS);
`endif

  state_e      state_q, state_d;
  logic        init_mode_q;
  logic [2:0]  step_q, step_d;
  logic [15:0] wdata_q, wdata_d;
  logic        id_q, id_d;
  logic [15:0] dly_ms_q, dly_ms_d;
  logic [19:0] presc_q, presc_d;
  logic [15:0] ms_q, ms_d;

  entry_e      rom_type;
  logic [15:0] rom_value;
  logic [15:0] tgt_ms;
  logic        timed;
  logic        presc_wrap;
  logic        tmr_done;
  logic        start;
  logic        fall;
  logic        abort;
  logic        winc_c;

  // Start only on a fresh rising edge; a falling edge aborts an active run,
  // but a run that has already reached DONE is allowed to finish.
  assign start = init_mode & ~init_mode_q;
  assign fall  = ~init_mode & init_mode_q;
  assign abort = fall && (state_q != IDLE) && (state_q != DONE);

  // Fixed init table, indexed by the step counter; index 7 is END so the
  // 3-bit step never wraps.
  always_comb begin
    rom_type  = ENT_END;
    rom_value = 16'h0000;
    case (step_q)
      3'd0: begin rom_type = ENT_CMD;  rom_value = 16'h0011; end
      3'd1: begin rom_type = ENT_DLY;  rom_value = 16'd120;  end
      3'd2: begin rom_type = ENT_CMD;  rom_value = 16'h003A; end
      3'd3: begin rom_type = ENT_DATA; rom_value = 16'h0055; end
      3'd4: begin rom_type = ENT_CMD;  rom_value = 16'h0036; end
      3'd5: begin rom_type = ENT_DATA; rom_value = 16'h0048; end
      3'd6: begin rom_type = ENT_CMD;  rom_value = 16'h0029; end
      default: begin rom_type = ENT_END; rom_value = 16'h0000; end
    endcase
  end

  // Millisecond timer shared by every timed state: counters sit at zero
  // outside timed states, so each timed state always starts from a clean count.
  always_comb begin
    tgt_ms = dly_ms_q;
    timed  = (state_q == DELAY);
`ifdef LCD_INIT_HWRST_EN
    if (state_q == RST_LO) begin
      tgt_ms = RST_LOW_MS16;
      timed  = 1'b1;
    end else if (state_q == RST_WAIT) begin
      tgt_ms = RST_WAIT_MS16;
      timed  = 1'b1;
    end
`endif
    presc_wrap = (presc_q == PRESC_LAST);
    tmr_done   = (tgt_ms == 16'd0) || (presc_wrap && (ms_q == tgt_ms - 16'd1));
    presc_d    = '0;
    ms_d       = '0;
    if (timed && !tmr_done && !abort) begin
      presc_d = presc_wrap ? 20'd0 : presc_q + 20'd1;
      ms_d    = presc_wrap ? ms_q + 16'd1 : ms_q;
    end
  end

  // Sequencer next-state and strobes; an abort overrides whatever the
  // current state decided.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    wdata_d  = wdata_q;
    id_d     = id_q;
    dly_ms_d = dly_ms_q;
    winc_c   = 1'b0;
    init_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          step_d = 3'd0;
`ifdef LCD_INIT_HWRST_EN
          state_d = RST_LO;
`else
          state_d = FETCH;
`endif
        end
      end
`ifdef LCD_INIT_HWRST_EN
      RST_LO: begin
        if (tmr_done) state_d = RST_WAIT;
      end
      RST_WAIT: begin
        if (tmr_done) state_d = FETCH;
      end
`endif
      FETCH: begin
        case (rom_type)
          ENT_CMD, ENT_DATA: begin
            wdata_d = rom_value;
            id_d    = (rom_type == ENT_DATA);
            state_d = WRITE;
          end
          ENT_DLY: begin
            dly_ms_d = rom_value;
            state_d  = DELAY;
          end
          default: state_d = DONE;
        endcase
      end
      WRITE: begin
        if (!wr.wfull) begin
          winc_c  = 1'b1;
          step_d  = step_q + 3'd1;
          state_d = FETCH;
        end
      end
      DELAY: begin
        if (tmr_done) begin
          step_d  = step_q + 3'd1;
          state_d = FETCH;
        end
      end
      DONE: begin
        init_end = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      winc_c  = 1'b0;
    end
  end

  // State, step, latched word and timer registers; reset discards all progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      init_mode_q <= 1'b0;
      step_q      <= 3'd0;
      wdata_q     <= 16'h0000;
      id_q        <= 1'b0;
      dly_ms_q    <= 16'h0000;
      presc_q     <= 20'd0;
      ms_q        <= 16'd0;
    end else begin
      state_q     <= state_d;
      init_mode_q <= init_mode;
      step_q      <= step_d;
      wdata_q     <= wdata_d;
      id_q        <= id_d;
      dly_ms_q    <= dly_ms_d;
      presc_q     <= presc_d;
      ms_q        <= ms_d;
    end
  end

  assign wr.winc  = winc_c;
  assign wr.wdata = wdata_q;
  assign wr.ID    = id_q;
  assign busy     = (state_q != IDLE);

`ifdef LCD_INIT_HWRST_EN
  assign lcd_rst_n = ~((state_q == RST_LO) && !abort);
`else
  assign lcd_rst_n = 1'b1;
`endif

endmodule

// File: doc/lcd_init_seq.md
LCD_INIT_SEQ -- requirements
Module: lcd_init_seq

Interface
REQ-001 Parameter CYC_PER_MS, default 50000: clk cycles per millisecond tick.
REQ-002 Parameter RST_LOW_MS, default 10: LCD hard-reset low time, in ms.
REQ-003 Parameter RST_WAIT_MS, default 120: wait after hard-reset release, in ms.
REQ-004 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-005 Port rst_n  input  1: asynchronous, active-low reset.
REQ-006 Port init_mode  input  1: high while the printer controller sits in its Init state.
REQ-007 Port wfull  input  1: LCD write-FIFO full.
REQ-008 Port winc  output  1: LCD write-FIFO push strobe.
REQ-009 Port wdata  output  16: word pushed with winc.
REQ-010 Port ID  output  1: type of the pushed word; 0 = instruction, 1 = data.
REQ-011 Port init_end  output  1: one-cycle pulse marking a completed sequence.
REQ-012 Port lcd_rst_n  output  1: LCD hardware reset pin, active low.
REQ-013 Port busy  output  1: high whenever the state is not IDLE.

Function
REQ-014 The block SHALL implement states IDLE, RST_LO, RST_WAIT, FETCH, WRITE, DELAY and DONE.
REQ-015 The block SHALL start a sequence only on a rising edge of init_mode, detected against a registered copy of init_mode; a level held high after DONE SHALL NOT restart it.
REQ-016 On start, the next state SHALL be RST_LO (with INIT_HWRST_EN) and the step index SHALL clear to 0.
REQ-017 In RST_LO, lcd_rst_n SHALL be 0 for exactly RST_LOW_MS*CYC_PER_MS cycles, then the state SHALL go to RST_WAIT.
REQ-018 In RST_WAIT, lcd_rst_n SHALL be 1 for exactly RST_WAIT_MS*CYC_PER_MS cycles, then the state SHALL go to FETCH.
REQ-019 The table SHALL be a fixed case-ROM; each entry is a {type, value[15:0]} pair, with type one of CMD, DATA, DLY or END.
REQ-020 Table contents, indices 0-7: CMD 0x0011; DLY 120; CMD 0x003A; DATA 0x0055; CMD 0x0036; DATA 0x0048; CMD 0x0029; END.
REQ-021 FETCH SHALL take one cycle to register the entry at the step index. It SHALL then go to WRITE (CMD/DATA), DELAY (DLY) or DONE (END).
REQ-022 In WRITE with wfull=1: winc=0, state held, and wdata/ID held stable.
REQ-023 In WRITE with wfull=0: winc=1 for exactly one cycle with wdata=value and ID=1 for DATA or 0 for CMD; the step index SHALL increment and the state SHALL go to FETCH.
REQ-024 DELAY SHALL last exactly value*CYC_PER_MS cycles, then increment the step index and go to FETCH; value=0 SHALL advance on the next cycle.
REQ-025 Delay timing SHALL use a 20-bit cycle prescaler and a 16-bit ms counter, both cleared on entry to any timed state.
REQ-026 DONE SHALL assert init_end for one cycle and return to IDLE on the next edge.
REQ-027 A falling edge of init_mode in any state other than IDLE or DONE SHALL abort to IDLE; no init_end, winc=0, lcd_rst_n=1.
REQ-028 winc SHALL be 0 in every state except WRITE with wfull=0.
REQ-029 The step index SHALL be 3 bits; END at index 7 guarantees no wrap.

Reset
REQ-030 While rst_n=0, the state SHALL be IDLE immediately (asynchronously).
REQ-031 While rst_n=0, the outputs SHALL be winc=0, wdata=0, ID=0, init_end=0, lcd_rst_n=1 and busy=0.
REQ-032 While rst_n=0, the counters, step index and registered init_mode SHALL be 0.
REQ-033 Reset asserted mid-sequence SHALL discard progress; a new init_mode rising edge restarts from the beginning.

Configuration
REQ-034 With macro LCD_INIT_HWRST_EN defined, the hard-reset phase SHALL be compiled in: start goes to RST_LO, then RST_WAIT.
REQ-035 Without LCD_INIT_HWRST_EN, RST_LO, RST_WAIT and their logic SHALL be absent: start goes directly to FETCH and lcd_rst_n is constant 1.

Verification
REQ-036 Bench parameters SHALL be CYC_PER_MS=4, RST_LOW_MS=2 and RST_WAIT_MS=3, with LCD_INIT_HWRST_EN defined unless stated otherwise.
REQ-037 init_mode rises, wfull=0 -> lcd_rst_n low 8 cycles, high 12 cycles, then six winc pulses: 0x0011/ID0, 0x003A/ID0, 0x0055/ID1, 0x0036/ID0, 0x0048/ID1, 0x0029/ID0; then init_end pulses once.
REQ-038 Same stimulus -> gap between the 0x0011 push and the 0x003A push equals 1+480+1 cycles.
REQ-039 wfull=1 for 5 cycles while in WRITE of 0x0055 -> no winc, wdata=0x0055 and ID=1 stable, then a single push on the cycle wfull=0.
REQ-040 init_mode held high for 50 cycles after init_end -> no further winc and busy=0; a low-then-high edge restarts the sequence.
REQ-041 rst_n pulsed low during DELAY -> immediate IDLE with lcd_rst_n=1 and busy=0, and no init_end.
REQ-042 LCD_INIT_HWRST_EN undefined -> first winc (0x0011) two cycles after the rising edge of init_mode, and lcd_rst_n never low.
